id_ex_skid_stage: RTL and testbench
===================================

# id_ex_skid_stage

Parametrised ID/EX pipeline stage with a valid/ready handshake, a one-entry skid buffer, stall back-pressure, bubble-injecting flush and a saturating stall counter. It sits between decode and execute and replaces the fixed 16-bit, 3-bit-rd, always-loading ID/EX register. Operand count, datapath width, register-address width and control-bundle width are parameters.

## Interface
- DATA_W, 16, operand/immediate width
- REG_AW, 3, destination register address width
- NUM_OPS, 2, number of register operands carried
- CTRL_W, 8, control bundle width; field layout is defined in the package
- STALL_W, 8, stall counter width
- clk  in  1  clock; rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  decode beat present
- in_ready  out  1  stage can accept a beat
- in_ops  in  NUM_OPS*DATA_W  operands; op0 is in bits [DATA_W-1:0]
- in_imm  in  DATA_W  extended immediate
- in_rd  in  REG_AW  destination register
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  beat presented to execute
- out_ready  in  1  execute accepts the beat
- out_ops, out_imm, out_rd  out  as inputs  payload of the main entry
- out_ctrl  out  CTRL_W  main-entry control; forced to 0 when out_valid=0
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  STALL_W  saturating count of stalled cycles

## Operation
- Two entries: main M, which drives the outputs, and skid S. Each entry has a valid bit, payload and control.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = !S.valid. It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = M.valid. occupancy = M.valid + S.valid.
- States: EMPTY (no entry valid), ONE (M valid), FULL (M and S valid).
- EMPTY: in_fire loads M and moves to ONE. Otherwise the state holds.
- ONE:
  - in_fire & out_fire: load M, stay in ONE.
  - out_fire only: move to EMPTY.
  - in_fire only: load S, move to FULL.
  - Neither: hold.
- FULL: in_ready=0. out_fire copies S into M and moves to ONE. Otherwise hold.
- Flush has priority over every transition:
  - M.valid, S.valid and both control fields are cleared to 0, and the state becomes EMPTY.
  - Payload registers (ops, imm, rd) hold their values.
  - A beat that handshakes in the flush cycle is dropped.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^STALL_W-1.
  - Cleared only by reset; flush does not clear it.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush.

## Timing
- Latency: a beat accepted at edge N is visible on out_* after edge N, provided the stage was EMPTY, or was ONE with out_fire in the same cycle.
- Throughput: one beat per cycle while out_ready=1.
- in_ready falls in the cycle after S fills, and rises in the cycle after S drains.
- Reset values:
  - out_valid=0, out_ctrl=0, out_ops=0, out_imm=0, out_rd=0
  - occupancy=0, stall_cnt=0
  - in_ready=1, state EMPTY
- Reset asserted mid-stream discards M and S immediately (asynchronously).

## Structure
- Package id_ex_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - control-field bit indices: REGWRITE=0, ALUSRCB=1, MEMREAD=2, MEMWRITE=3, MEMTOREG=4, ALUOP=7:5;
  - the default widths.
- Sub-module pipe_entry is one valid+payload+control register with load, clear-control and hold inputs. It is instantiated twice, as M and S.
- The FSM, handshake logic and counter live in the top module.

## Test plan
- Streaming: 4 beats (ops=0x0011/0x0022 … 0x0044/0x0088, rd=1..4) with out_ready=1. Required: outputs in order, one per cycle after a 1-cycle latency, occupancy never exceeds 1.
- Back-pressure:
  - Stimulus: beats A and B sent while out_ready=0, then hold 3 cycles.
  - Required: in_ready=0 after B is taken; occupancy=2; out shows A; stall_cnt=4.
  - Then raise out_ready: A and B leave in order and in_ready returns to 1.
- Flush in FULL with an incoming beat C. Required next cycle: out_valid=0, out_ctrl=0, occupancy=0, out_ops unchanged, C never appears.
- Saturation: STALL_W=3 with out_valid held and out_ready=0 for 10 cycles. Required: stall_cnt=7.
- Async reset: assert rst_n=0 mid-cycle while FULL. Required immediately: out_valid=0 and occupancy=0; in_ready=1 after release.
- Parameter sweep: NUM_OPS=3, DATA_W=32, REG_AW=5 streaming test. Required: bit-exact payload passthrough, including op2 in bits [95:64].

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX skid stage: default widths, control-bundle
// field positions and the stage occupancy state encoding.
package id_ex_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_AW_DEF  = 3;
    localparam int NUM_OPS_DEF = 2;
    localparam int CTRL_W_DEF  = 8;
    localparam int STALL_W_DEF = 8;

    // Bit positions inside the control bundle.
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_ALUSRCB   = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_MEMTOREG  = 4;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_ALUOP_MSB = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid bit, payload and control. Clear wins over hold,
// hold wins over load; with neither hold nor load the entry drains (valid drops).
module pipe_entry
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      clr_i,
    input  logic                      hold_i,
    input  logic [NUM_OPS*DATA_W-1:0] ops_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [REG_AW-1:0]         rd_i,
    input  logic [CTRL_W-1:0]         ctrl_i,
    output logic                      vld_o,
    output logic [NUM_OPS*DATA_W-1:0] ops_o,
    output logic [DATA_W-1:0]         imm_o,
    output logic [REG_AW-1:0]         rd_o,
    output logic [CTRL_W-1:0]         ctrl_o
);

    logic                      vld_q;
    logic [NUM_OPS*DATA_W-1:0] ops_q;
    logic [DATA_W-1:0]         imm_q;
    logic [REG_AW-1:0]         rd_q;
    logic [CTRL_W-1:0]         ctrl_q;

    // Clear only kills valid and control; the payload is left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ops_q  <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else if (!hold_i) begin
            vld_q <= load_i;
            if (load_i) begin
                ops_q  <= ops_i;
                imm_q  <= imm_i;
                rd_q   <= rd_i;
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign ops_o  = ops_q;
    assign imm_o  = imm_q;
    assign rd_o   = rd_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage with a one-entry skid buffer; in_ready depends on registered
// state only, flush drops every held and incoming beat, stalled cycles are counted.
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int STALL_W = STALL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_imm,
    output logic [REG_AW-1:0]         out_rd,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [1:0]                occupancy,
    output logic [STALL_W-1:0]        stall_cnt
);

    localparam int OPS_W = NUM_OPS * DATA_W;

    stage_state_e state_q, state_d;

    logic              m_vld, s_vld;
    logic [OPS_W-1:0]  m_ops, s_ops, m_ops_in;
    logic [DATA_W-1:0] m_imm, s_imm, m_imm_in;
    logic [REG_AW-1:0] m_rd, s_rd, m_rd_in;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;

    logic m_load, m_hold, s_load, s_hold, m_from_s;
    logic in_fire, out_fire;

    logic [STALL_W-1:0] stall_q, stall_d;

    assign in_ready  = !s_vld;
    assign out_valid = m_vld;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_hold   = 1'b1;
        s_load   = 1'b0;
        s_hold   = 1'b1;
        m_from_s = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    m_hold  = 1'b0;
                    m_load  = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_hold = 1'b0;
                    m_load = 1'b1;
                end else if (out_fire) begin
                    m_hold  = 1'b0;
                    state_d = EMPTY;
                end else if (in_fire) begin
                    s_hold  = 1'b0;
                    s_load  = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                // Skid entry moves forward and drains in the same edge.
                if (out_fire) begin
                    m_hold   = 1'b0;
                    m_load   = 1'b1;
                    m_from_s = 1'b1;
                    s_hold   = 1'b0;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign m_ops_in  = m_from_s ? s_ops  : in_ops;
    assign m_imm_in  = m_from_s ? s_imm  : in_imm;
    assign m_rd_in   = m_from_s ? s_rd   : in_rd;
    assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;

    pipe_entry #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .NUM_OPS(NUM_OPS),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(m_load),
        .clr_i (flush),
        .hold_i(m_hold),
        .ops_i (m_ops_in),
        .imm_i (m_imm_in),
        .rd_i  (m_rd_in),
        .ctrl_i(m_ctrl_in),
        .vld_o (m_vld),
        .ops_o (m_ops),
        .imm_o (m_imm),
        .rd_o  (m_rd),
        .ctrl_o(m_ctrl)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .NUM_OPS(NUM_OPS),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(s_load),
        .clr_i (flush),
        .hold_i(s_hold),
        .ops_i (in_ops),
        .imm_i (in_imm),
        .rd_i  (in_rd),
        .ctrl_i(in_ctrl),
        .vld_o (s_vld),
        .ops_o (s_ops),
        .imm_o (s_imm),
        .rd_o  (s_rd),
        .ctrl_o(s_ctrl)
    );

    assign out_ops   = m_ops;
    assign out_imm   = m_imm;
    assign out_rd    = m_rd;
    assign out_ctrl  = m_vld ? m_ctrl : '0;
    assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Drives a default-width and a wide (3x32, 5-bit rd, 3-bit counter) instance with the
// same handshake stimulus and checks both against a queue-based reference model.
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [95:0] ops;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } beat_t;

    logic clk, rst_n, flush, in_valid, out_ready;
    beat_t cur;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_ops;
    logic [15:0] n_out_imm;
    logic [2:0]  n_out_rd;
    logic [7:0]  n_out_ctrl;
    logic [1:0]  n_occ;
    logic [7:0]  n_stall;

    logic        w_in_ready, w_out_valid;
    logic [95:0] w_out_ops;
    logic [31:0] w_out_imm;
    logic [4:0]  w_out_rd;
    logic [7:0]  w_out_ctrl;
    logic [1:0]  w_occ;
    logic [2:0]  w_stall;

    beat_t       q[$];
    beat_t       last_head;
    int unsigned stall_ref;
    int          compared, mismatched;
    beat_t       ba, bb;

    id_ex_skid_stage u_narrow (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ops({cur.ops[47:32], cur.ops[15:0]}), .in_imm(cur.imm[15:0]),
        .in_rd(cur.rd[2:0]), .in_ctrl(cur.ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_ops(n_out_ops), .out_imm(n_out_imm), .out_rd(n_out_rd),
        .out_ctrl(n_out_ctrl), .occupancy(n_occ), .stall_cnt(n_stall)
    );

    id_ex_skid_stage #(
        .DATA_W(32), .REG_AW(5), .NUM_OPS(3), .CTRL_W(8), .STALL_W(3)
    ) u_wide (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_ops(cur.ops), .in_imm(cur.imm), .in_rd(cur.rd), .in_ctrl(cur.ctrl),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_ops(w_out_ops), .out_imm(w_out_imm), .out_rd(w_out_rd),
        .out_ctrl(w_out_ctrl), .occupancy(w_occ), .stall_cnt(w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        b.ops  = {$urandom, $urandom, $urandom};
        b.imm  = $urandom;
        b.rd   = 5'($urandom);
        b.ctrl = 8'($urandom);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        last_head = '0;
        stall_ref = 0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_step();
        bit inf, outf;
        inf  = in_valid && (q.size() < 2);
        outf = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && !flush) stall_ref++;
        if (flush) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(cur);
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    task automatic check_all();
        bit    ev;
        beat_t h;
        ev = q.size() > 0;
        h  = ev ? q[0] : last_head;
        chk("n_in_ready",  128'(n_in_ready),  128'(q.size() < 2));
        chk("n_out_valid", 128'(n_out_valid), 128'(ev));
        chk("n_occupancy", 128'(n_occ),       128'(q.size()));
        chk("n_out_ctrl",  128'(n_out_ctrl),  128'(ev ? h.ctrl : 8'h00));
        chk("n_out_ops",   128'(n_out_ops),   128'({h.ops[47:32], h.ops[15:0]}));
        chk("n_out_imm",   128'(n_out_imm),   128'(h.imm[15:0]));
        chk("n_out_rd",    128'(n_out_rd),    128'(h.rd[2:0]));
        chk("n_stall_cnt", 128'(n_stall),     128'((stall_ref > 255) ? 255 : stall_ref));
        chk("w_in_ready",  128'(w_in_ready),  128'(q.size() < 2));
        chk("w_out_valid", 128'(w_out_valid), 128'(ev));
        chk("w_occupancy", 128'(w_occ),       128'(q.size()));
        chk("w_out_ctrl",  128'(w_out_ctrl),  128'(ev ? h.ctrl : 8'h00));
        chk("w_out_ops",   128'(w_out_ops),   128'(h.ops));
        chk("w_out_imm",   128'(w_out_imm),   128'(h.imm));
        chk("w_out_rd",    128'(w_out_rd),    128'(h.rd));
        chk("w_stall_cnt", 128'(w_stall),     128'((stall_ref > 7) ? 7 : stall_ref));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        cur        = '0;
        model_reset();
        #12;
        check_all();
        chk("reset_in_ready", 128'(n_in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: four beats back to back with the consumer always ready.
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cur = rnd_beat();
            cur.ops[15:0]  = 16'(16'h0011 * k);
            cur.ops[47:32] = 16'(16'h0022 * k);
            cur.rd         = 5'(k);
            in_valid       = 1'b1;
            cycle();
            chk("stream_out_ops", 128'(n_out_ops), 128'({16'(16'h0022 * k), 16'(16'h0011 * k)}));
            chk("stream_occ_le1", 128'(n_occ <= 2'd1), 128'(1));
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // Back-pressure: A then B with the consumer stalled, then hold.
        out_ready = 1'b0;
        ba = rnd_beat();
        bb = rnd_beat();
        cur = ba; in_valid = 1'b1; cycle();
        cur = bb; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_in_ready", 128'(n_in_ready), 128'(0));
        chk("bp_occ", 128'(n_occ), 128'(2));
        chk("bp_out_a", 128'(w_out_ops), 128'(ba.ops));
        chk("bp_stall_n", 128'(n_stall), 128'(4));
        chk("bp_stall_w", 128'(w_stall), 128'(4));
        out_ready = 1'b1;
        cycle();
        chk("bp_out_b", 128'(w_out_ops), 128'(bb.ops));
        chk("bp_in_ready_back", 128'(n_in_ready), 128'(1));
        cycle();

        // Flush while FULL with a beat C arriving the same cycle.
        out_ready = 1'b0;
        ba = rnd_beat();
        cur = ba; in_valid = 1'b1; cycle();
        cur = rnd_beat(); cycle();
        cur = rnd_beat(); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 128'(n_out_valid), 128'(0));
        chk("fl_out_ctrl", 128'(w_out_ctrl), 128'(0));
        chk("fl_occ", 128'(w_occ), 128'(0));
        chk("fl_ops_held", 128'(w_out_ops), 128'(ba.ops));
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("fl_no_c", 128'(w_out_valid), 128'(0));

        // Saturation of the 3-bit counter.
        out_ready = 1'b0;
        cur = rnd_beat(); in_valid = 1'b1; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("sat_stall_w", 128'(w_stall), 128'(7));
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        cur = rnd_beat(); in_valid = 1'b1; cycle();
        cur = rnd_beat(); cycle();
        in_valid = 1'b0;
        chk("ar_full", 128'(n_occ), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_out_valid", 128'(n_out_valid), 128'(0));
        chk("ar_occ", 128'(w_occ), 128'(0));
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", 128'(n_in_ready), 128'(1));

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cur       = rnd_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
